// File: rtl/cmp_pkg.sv
// Shared types and flag decoding for the comparator result monitor.
package cmp_pkg;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_LT   = 2'b01,
        RES_EQ   = 2'b10,
        RES_GT   = 2'b11
    } result_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_LOCKED
    } state_e;

    typedef struct packed {
        logic    legal;
        result_e code;
    } decode_t;

    // Only a one-hot {gt,eq,lt} is a legal comparator outcome.
    function automatic decode_t decode_flags(input logic gt, input logic eq, input logic lt);
        decode_t d;
        d.legal = 1'b1;
        case ({gt, eq, lt})
            3'b100:  d.code = RES_GT;
            3'b010:  d.code = RES_EQ;
            3'b001:  d.code = RES_LT;
            default: begin
                d.code  = RES_NONE;
                d.legal = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cmp_result_monitor_if.sv
// Sample and status bundle between the comparator harness and the result monitor.
interface cmp_result_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             clr;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [1:0]       last_result;
    logic             out_valid;
    logic             err;
    logic             locked;

    modport master (
        output in_valid, gt, eq, lt, clr,
        input  gt_cnt, eq_cnt, lt_cnt, last_result, out_valid, err, locked
    );

    modport slave (
        input  in_valid, gt, eq, lt, clr,
        output gt_cnt, eq_cnt, lt_cnt, last_result, out_valid, err, locked
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones, with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;
endmodule

// File: rtl/cmp_result_monitor.sv
// Tallies comparator outcomes, flags illegal flag sets and tracks an equal-run lock.
module cmp_result_monitor
    import cmp_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_LEN = 4
) (
    input logic                 clk,
    input logic                 rst,
    cmp_result_monitor_if.slave mon
);
    localparam int unsigned       RunW   = $clog2(LOCK_LEN + 1);
    localparam logic [RunW-1:0]   RunMax = RunW'(LOCK_LEN);

    decode_t         dec;
    logic            accept;
    logic            inc_gt, inc_eq, inc_lt;
    logic [RunW-1:0] run_d, run_q;
    state_e          state_d, state_q;
    result_e         last_d, last_q;
    logic            out_valid_d, out_valid_q;
    logic            err_d, err_q;
    logic            locked_d, locked_q;

    assign dec    = decode_flags(mon.gt, mon.eq, mon.lt);
    // clr takes priority, so a coincident sample is discarded.
    assign accept = mon.in_valid & ~mon.clr;
    assign inc_gt = accept & dec.legal & (dec.code == RES_GT);
    assign inc_eq = accept & dec.legal & (dec.code == RES_EQ);
    assign inc_lt = accept & dec.legal & (dec.code == RES_LT);

    always_comb begin
        run_d       = run_q;
        state_d     = state_q;
        last_d      = last_q;
        out_valid_d = accept;
        err_d       = accept & ~dec.legal;
        if (mon.clr) begin
            run_d   = '0;
            state_d = ST_IDLE;
            last_d  = RES_NONE;
        end else if (accept) begin
            if (inc_eq) begin
                run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;
            end else begin
                run_d = '0;
            end
            if (dec.legal) begin
                last_d = dec.code;
            end
            // Every accepted sample lands in TRACK unless it completes the eq run.
            state_d = (inc_eq && (run_d == RunMax)) ? ST_LOCKED : ST_TRACK;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= '0;
            state_q     <= ST_IDLE;
            last_q      <= RES_NONE;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            run_q       <= run_d;
            state_q     <= state_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (mon.clr),
        .inc (inc_gt),
        .q   (mon.gt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .clk (clk),
        .rst (rst),
        .clr (mon.clr),
        .inc (inc_eq),
        .q   (mon.eq_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (mon.clr),
        .inc (inc_lt),
        .q   (mon.lt_cnt)
    );

    assign mon.last_result = last_q;
    assign mon.out_valid   = out_valid_q;
    assign mon.err         = err_q;
    assign mon.locked      = locked_q;
endmodule
